// File: rtl/openflow_action_engine_pkg.sv
// Shared constants, action layout and rewrite helper for the OpenFlow action engine.
// Field positions index into the action data bus; flags arrive on the action ctrl bus.
package openflow_action_engine_pkg;

    localparam int OF_DST_PORT_WIDTH    = 16;
    localparam int OF_DL_ADDR_WIDTH     = 48;
    localparam int OF_DST_PORT_POS      = 0;
    localparam int OF_DL_DST_POS        = 16;
    localparam int OF_DL_SRC_POS        = 64;
    localparam int OF_ACTION_DATA_WIDTH = 112;
    localparam int OF_ACTION_CTRL_WIDTH = 4;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [1:0] WORD_CNT_MAX       = 2'd2;

    typedef enum logic [1:0] {
        S_WAIT_ACT = 2'd0,
        S_HDR      = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    typedef struct packed {
        logic drop;
        logic set_sa;
        logic set_da;
        logic set_port;
    } act_flags_t;

    typedef struct packed {
        act_flags_t                    flags;
        logic [OF_DL_ADDR_WIDTH-1:0]   dl_src;
        logic [OF_DL_ADDR_WIDTH-1:0]   dl_dst;
        logic [OF_DST_PORT_WIDTH-1:0]  dst_port;
    } act_t;

    // Ethernet DA occupies data word 0 [63:16]; SA straddles word 0 [15:0] and word 1 [63:32].
    function automatic logic [63:0] rewrite_data_word(input logic [63:0] word,
                                                      input logic [1:0]  idx,
                                                      input act_t        act);
        logic [63:0] w;
        w = word;
        if (idx == 2'd0) begin
            if (act.flags.set_da) w[63:16] = act.dl_dst;
            if (act.flags.set_sa) w[15:0]  = act.dl_src[47:32];
        end else if (idx == 2'd1 && act.flags.set_sa) begin
            w[63:32] = act.dl_src[31:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/openflow_action_engine_if.sv
// Packet word stream: data/ctrl/wr from the producer, rdy back from the consumer.
interface openflow_action_engine_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input  rdy);
    modport slave  (input  data, input  ctrl, input  wr, output rdy);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head entry whenever empty is low.
// Writes while full and reads while empty are ignored.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_C   = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_C  = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      full, wr_ok, rd_ok;

    assign full        = (count == DEPTH_C);
    assign nearly_full = (count >= NEARLY_C);
    assign empty       = (count == '0);
    assign wr_ok       = wr_en & ~full;
    assign rd_ok       = rd_en & ~empty;
    assign dout        = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; count and pointers alone
    // define which entries are valid, and a reset memory would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/openflow_action_engine.sv
// Per-packet OpenFlow action applier: pops one action per packet, rewrites port/DA/SA.
// Optional drop support is compiled in with the ACTION_DROP_EN macro.
module openflow_action_engine
    import openflow_action_engine_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int ACT_DATA_WIDTH      = OF_ACTION_DATA_WIDTH,
    parameter int ACT_CTRL_WIDTH      = OF_ACTION_CTRL_WIDTH,
    parameter int ACT_FIFO_DEPTH_BITS = 2,
    parameter int UDP_REG_SRC_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,

    openflow_action_engine_if.slave         in_if,
    openflow_action_engine_if.master        out_if,

    input  logic [ACT_DATA_WIDTH-1:0]       action_data_bus,
    input  logic [ACT_CTRL_WIDTH-1:0]       action_ctrl_bus,
    input  logic                            action_valid,
    output logic                            action_rdy,

    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_l_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_l_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);
    assign reg_req_out     = reg_req_in;
    assign reg_ack_out     = reg_ack_in;
    assign reg_rd_wr_l_out = reg_rd_wr_l_in;
    assign reg_addr_out    = reg_addr_in;
    assign reg_data_out    = reg_data_in;
    assign reg_src_out     = reg_src_in;

    logic [ACT_DATA_WIDTH+ACT_CTRL_WIDTH-1:0] fifo_dout;
    logic fifo_empty, fifo_nearly_full, fifo_pop;

    fallthrough_small_fifo #(
        .WIDTH          (ACT_DATA_WIDTH + ACT_CTRL_WIDTH),
        .MAX_DEPTH_BITS (ACT_FIFO_DEPTH_BITS)
    ) u_act_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         ({action_ctrl_bus, action_data_bus}),
        .wr_en       (action_valid),
        .rd_en       (fifo_pop),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign action_rdy = ~fifo_nearly_full;

    act_t act_head, act_reg;
    assign act_head = {fifo_dout[ACT_DATA_WIDTH +: ACT_CTRL_WIDTH],
                       fifo_dout[OF_DL_SRC_POS +: OF_DL_ADDR_WIDTH],
                       fifo_dout[OF_DL_DST_POS +: OF_DL_ADDR_WIDTH],
                       fifo_dout[OF_DST_PORT_POS +: OF_DST_PORT_WIDTH]};

    // The drop decision is taken from the FIFO head at pop time, never from act_reg.
    logic unused_drop_bits;
    assign unused_drop_bits = act_head.flags.drop ^ act_reg.flags.drop;

    state_t                state, state_nxt;
    logic [1:0]            word_cnt, word_cnt_nxt;
    logic                  in_rdy, accept, end_of_pkt;
    logic                  out_wr, out_wr_nxt;
    logic [DATA_WIDTH-1:0] out_data, out_data_nxt;
    logic [CTRL_WIDTH-1:0] out_ctrl;

    assign in_rdy      = out_if.rdy & (state != S_WAIT_ACT);
    assign accept      = in_if.wr & in_rdy;
    assign in_if.rdy   = in_rdy;
    assign out_if.wr   = out_wr;
    assign out_if.data = out_data;
    assign out_if.ctrl = out_ctrl;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        fifo_pop     = 1'b0;
        end_of_pkt   = 1'b0;
        out_wr_nxt   = 1'b0;
        out_data_nxt = in_if.data;

        unique case (state)
            S_WAIT_ACT: fifo_pop = ~fifo_empty;
            S_HDR: if (accept) begin
                out_wr_nxt = 1'b1;
                if (in_if.ctrl == IO_QUEUE_STAGE_NUM) begin
                    if (act_reg.flags.set_port) out_data_nxt[63:48] = act_reg.dst_port;
                end else if (in_if.ctrl == '0) begin
                    out_data_nxt = rewrite_data_word(in_if.data, 2'd0, act_reg);
                    word_cnt_nxt = 2'd1;
                    state_nxt    = S_DATA;
                end
            end
            S_DATA: if (accept) begin
                out_wr_nxt = 1'b1;
                if (in_if.ctrl != '0) begin
                    end_of_pkt = 1'b1;
                end else begin
                    out_data_nxt = rewrite_data_word(in_if.data, word_cnt, act_reg);
                    if (word_cnt != WORD_CNT_MAX) word_cnt_nxt = word_cnt + 2'd1;
                end
            end
`ifdef ACTION_DROP_EN
            // word_cnt != 0 marks that the body has started, so a later ctrl word is the EOP.
            S_DROP: if (accept) begin
                if (in_if.ctrl == '0)    word_cnt_nxt = 2'd1;
                else if (word_cnt != '0) end_of_pkt   = 1'b1;
            end
`endif
            default: state_nxt = S_WAIT_ACT;
        endcase

        // Popping on the EOP cycle lets the next header follow without a bubble.
        if (end_of_pkt) begin
            state_nxt = S_WAIT_ACT;
            fifo_pop  = ~fifo_empty;
        end
        if (fifo_pop) begin
            word_cnt_nxt = '0;
            state_nxt    = S_HDR;
`ifdef ACTION_DROP_EN
            if (act_head.flags.drop) state_nxt = S_DROP;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_WAIT_ACT;
            word_cnt <= '0;
            act_reg  <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            out_wr   <= out_wr_nxt;
            if (fifo_pop) act_reg <= act_head;
            if (out_wr_nxt) begin
                out_data <= out_data_nxt;
                out_ctrl <= in_if.ctrl;
            end
        end
    end

endmodule
